// File: rtl/adder_arb_pkg.sv
// Shared defaults, width helper and result-entry type for the adder arbiter slice.
package adder_arb_pkg;

    localparam int unsigned DEF_DSIZE      = 64;
    localparam int unsigned DEF_NREQ       = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) result++;
        return result;
    endfunction

    localparam int unsigned DEF_IDW = clog2(DEF_NREQ);

    typedef struct packed {
        logic [DEF_IDW-1:0]   id;
        logic [DEF_DSIZE-1:0] sum;
    } result_t;

endpackage

// File: rtl/adder_arbiter_add4_pipe.sv
// Two-stage 4-operand adder: pair sums in stage 1, final sum in stage 2, no stall.
module add4_pipe #(
    parameter int unsigned DSIZE = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    input  logic [DSIZE-1:0] c,
    input  logic [DSIZE-1:0] d,
    output logic [DSIZE-1:0] sum
);

    logic [DSIZE-1:0] s1_ab;
    logic [DSIZE-1:0] s1_cd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ab <= '0;
            s1_cd <= '0;
            sum   <= '0;
        end else begin
            s1_ab <= a + b;
            s1_cd <= c + d;
            sum   <= s1_ab + s1_cd;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin, credit-gated front end sharing one add4_pipe among NREQ requesters,
// with an ID-tagged first-word-fall-through result FIFO.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned DSIZE      = DEF_DSIZE,
    parameter int unsigned NREQ       = DEF_NREQ,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned IDW       = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*DSIZE-1:0] req_a,
    input  logic [NREQ*DSIZE-1:0] req_b,
    input  logic [NREQ*DSIZE-1:0] req_c,
    input  logic [NREQ*DSIZE-1:0] req_d,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DSIZE-1:0]      rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    localparam int unsigned CW = clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [DSIZE-1:0] sum;
    } entry_t;

    logic [CW-1:0]    credit;
    logic [CW-1:0]    count;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic             issue;
    logic             pop;
    logic             push;
    logic [DSIZE-1:0] op_a, op_b, op_c, op_d;
    logic [DSIZE-1:0] sum2;
    logic             v1, v2;
    logic [IDW-1:0]   id1, id2;
    logic [PW-1:0]    wptr, rptr;
    entry_t           mem [FIFO_DEPTH];
    entry_t           head;

    always_comb begin
        cand      = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Registered credit only: a same-cycle pop cannot open the grant.
    always_comb begin
        req_ready = '0;
        if (credit != '0 && gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    assign issue = |req_ready;

    always_comb begin
        op_a = '0;
        op_b = '0;
        op_c = '0;
        op_d = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                op_a = req_a[i*DSIZE +: DSIZE];
                op_b = req_b[i*DSIZE +: DSIZE];
                op_c = req_c[i*DSIZE +: DSIZE];
                op_d = req_d[i*DSIZE +: DSIZE];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            credit <= CW'(FIFO_DEPTH);
        end else begin
            if (issue) ptr <= IDW'((32'(gnt_idx) + 1) % NREQ);
            if (issue && !pop)      credit <= credit - CW'(1);
            else if (pop && !issue) credit <= credit + CW'(1);
        end
    end

    add4_pipe #(.DSIZE(DSIZE)) u_add4_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (op_a),
        .b     (op_b),
        .c     (op_c),
        .d     (op_d),
        .sum   (sum2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            id1 <= '0;
            v2  <= 1'b0;
            id2 <= '0;
        end else begin
            v1  <= issue;
            id1 <= gnt_idx;
            v2  <= v1;
            id2 <= id1;
        end
    end

    assign push = v2;
    assign pop  = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= (wptr == PW'(FIFO_DEPTH - 1)) ? '0 : wptr + PW'(1);
            if (pop)  rptr <= (rptr == PW'(FIFO_DEPTH - 1)) ? '0 : rptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= '{id: id2, sum: sum2};
    end

    // Storage is not reset, so outputs are gated to read zero while empty.
    assign head      = mem[rptr];
    assign rsp_valid = (count != '0);
    assign rsp_sum   = rsp_valid ? head.sum : '0;
    assign rsp_id    = rsp_valid ? head.id  : '0;
    assign busy      = (credit != CW'(FIFO_DEPTH));

    a_credit_max: assert property (@(posedge clk) disable iff (!rst_n)
        credit <= CW'(FIFO_DEPTH));
    a_credit_min: assert property (@(posedge clk) disable iff (!rst_n)
        !(issue && credit == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: reset, latency, fairness, wrap, backpressure, credit, mid-op reset.
module tb_adder_arbiter;

    localparam int unsigned DSIZE      = 64;
    localparam int unsigned NREQ       = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned IDW        = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DSIZE-1:0] req_a, req_b, req_c, req_d;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DSIZE-1:0]      rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adder_arbiter #(
        .DSIZE      (DSIZE),
        .NREQ       (NREQ),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_d     (req_d),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic [63:0] d);
        req_a[i*DSIZE +: DSIZE] = a;
        req_b[i*DSIZE +: DSIZE] = b;
        req_c[i*DSIZE +: DSIZE] = c;
        req_d[i*DSIZE +: DSIZE] = d;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        req_d     = '0;
        rsp_ready = 1'b0;
        tick();

        // reset state; req 3 alone must win with full credit
        req_valid = 4'b1000;
        @(negedge clk);
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_sum",   64'(rsp_sum),   64'd0);
        check("rst_id",    64'(rsp_id),    64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_ready", 64'(req_ready), 64'h8);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // single request, latency 3
        set_ops(2, 64'd1, 64'd2, 64'd3, 64'd4);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) check("t1_grant", 64'(req_ready), 64'h4);
            check("t1_busy",  64'(busy),      (k >= 1 && k <= 3) ? 64'd1 : 64'd0);
            check("t1_valid", 64'(rsp_valid), (k == 3) ? 64'd1 : 64'd0);
            if (k == 3) begin
                check("t1_sum", 64'(rsp_sum), 64'd10);
                check("t1_id",  64'(rsp_id),  64'd2);
            end
            tick();
            req_valid = '0;
        end

        // fairness from ptr = 0
        do_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 64'(i * 16), 64'd1, 64'd2, 64'd3);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 6) check("fair_grant", 64'(req_ready), 64'(1) << (k % 4));
            check("fair_valid", 64'(rsp_valid), (k >= 3 && k <= 8) ? 64'd1 : 64'd0);
            if (k >= 3 && k <= 8) begin
                check("fair_id",  64'(rsp_id),  64'((k - 3) % 4));
                check("fair_sum", 64'(rsp_sum), 64'(((k - 3) % 4) * 16 + 6));
            end
            tick();
            if (k == 5) req_valid = '0;
        end

        // wrap-around arithmetic on requester 0
        set_ops(0, '1, '1, '1, '1);
        req_valid = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 2) check("wrap_grant", 64'(req_ready), 64'h1);
            if (k == 3) begin
                check("wrap_valid0", 64'(rsp_valid), 64'd1);
                check("wrap_ones",   64'(rsp_sum),   64'hFFFF_FFFF_FFFF_FFFC);
            end
            if (k == 4) begin
                check("wrap_valid1", 64'(rsp_valid), 64'd1);
                check("wrap_msb",    64'(rsp_sum),   64'd0);
                check("wrap_id",     64'(rsp_id),    64'd0);
            end
            if (k == 5) check("wrap_empty", 64'(rsp_valid), 64'd0);
            tick();
            if (k == 0) set_ops(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0);
            if (k == 1) req_valid = '0;
        end

        // backpressure and credit edge: pop in cycle 7 with credit 0
        rsp_ready = 1'b0;
        set_ops(0, 64'd100, 64'd0, 64'd0, 64'd0);
        req_valid = 4'b0001;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            if (k <= 3)      check("bp_grant",   64'(req_ready), 64'h1);
            else if (k <= 7) check("bp_stall",   64'(req_ready), 64'h0);
            else if (k == 8) check("bp_regrant", 64'(req_ready), 64'h1);
            if (k == 4) check("bp_busy", 64'(busy), 64'd1);
            if (k >= 3 && k <= 6) check("bp_head", 64'(rsp_sum), 64'd100);
            if (k >= 7 && k <= 11) begin
                check("bp_valid", 64'(rsp_valid), 64'd1);
                check("bp_sum",   64'(rsp_sum),   64'(100 + k - 7));
            end
            if (k == 12) begin
                check("bp_drained", 64'(rsp_valid), 64'd0);
                check("bp_idle",    64'(busy),      64'd0);
            end
            tick();
            if (k <= 3) set_ops(0, 64'(101 + k), 64'd0, 64'd0, 64'd0);
            if (k == 6) rsp_ready = 1'b1;
            if (k == 8) req_valid = '0;
        end

        // reset with one buffered and two in flight
        rsp_ready = 1'b0;
        set_ops(0, 64'd1, 64'd1, 64'd1, 64'd1);
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mr_grant", 64'(req_ready), 64'h1);
            tick();
        end
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("mr_valid", 64'(rsp_valid), 64'd0);
        check("mr_sum",   64'(rsp_sum),   64'd0);
        check("mr_busy",  64'(busy),      64'd0);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mr_no_stale", 64'(rsp_valid), 64'd0);
            check("mr_idle",     64'(busy),      64'd0);
            tick();
        end
        set_ops(1, 64'd5, 64'd6, 64'd7, 64'd8);
        req_valid = 4'b0010;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) check("mr_new_grant", 64'(req_ready), 64'h2);
            check("mr_new_valid", 64'(rsp_valid), (k == 3) ? 64'd1 : 64'd0);
            if (k == 3) begin
                check("mr_new_sum", 64'(rsp_sum), 64'd26);
                check("mr_new_id",  64'(rsp_id),  64'd1);
            end
            tick();
            req_valid = '0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
